// File: rtl/avalon_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : avalon_mem_arbiter
// Description : Two-requester Avalon-MM arbiter. It shares one slave between an
//               instruction-fetch port (read only) and a data port (read/write).
//               Arbitration takes one IDLE cycle, and each grant lasts until the
//               transfer completes or the owner withdraws its request.
//               Optional build macro ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration. Without the macro, the data port has fixed
//               priority.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module avalon_mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   // instruction-fetch requester
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   output logic [31:0]       i_readdata,
   output logic              i_waitrequest,
   // data requester
   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_writedata,
   input  logic [3:0]        d_byteenable,
   output logic [31:0]       d_readdata,
   output logic              d_waitrequest,
   // shared slave
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [31:0]       m_writedata,
   output logic [3:0]        m_byteenable,
   input  logic [31:0]       m_readdata,
   input  logic              m_waitrequest,
   // grant status
   output logic [1:0]        owner
);

   // State encoding doubles as the owner code.
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] BUS_I = 2'b01;
   localparam logic [1:0] BUS_D = 2'b10;

   localparam logic [3:0] ALL_LANES = 4'b1111;

   logic [1:0] state_q;
   logic [1:0] state_d;

   logic       i_req;
   logic       d_req;
   logic       grant_i;
   logic       grant_d;
   logic       i_done;
   logic       d_done;

   assign i_req  = i_read;
   assign d_req  = d_read | d_write;

   // A transfer completes only when the owner still requests and the slave
   // stops stalling. A withdrawn request is an abort and does not count.
   assign i_done = (state_q == BUS_I) & i_req & ~m_waitrequest;
   assign d_done = (state_q == BUS_D) & d_req & ~m_waitrequest;

`ifdef ARB_ROUND_ROBIN_EN
   // Set when the instruction port was served last. Reset chooses
   // "instruction", so the first contested grant goes to data.
   logic last_i_q;
   logic last_i_d;

   // Update the last-served flag only when a transfer completes.
   always_comb begin
      last_i_d = last_i_q;
      if (i_done) begin
         last_i_d = 1'b1;
      end else if (d_done) begin
         last_i_d = 1'b0;
      end
   end

   // Last-served register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_i_q <= 1'b1;
      end else begin
         last_i_q <= last_i_d;
      end
   end

   // On a contested request, grant the port that was not served last.
   assign grant_d = d_req & (~i_req | last_i_q);
   assign grant_i = i_req & ~grant_d;
`else
   // Fixed priority: the data port wins a contested request.
   assign grant_d = d_req;
   assign grant_i = i_req & ~d_req;

   // Completion flags matter only to the round-robin history.
   logic unused_done;
   assign unused_done = i_done ^ d_done;
`endif

   // State register; reset returns to IDLE immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: arbitrate in IDLE; hold a grant only while the owner
   // requests and the slave stalls.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = BUS_D;
            end else if (grant_i) begin
               state_d = BUS_I;
            end
         end
         BUS_I: begin
            if (!(i_req && m_waitrequest)) begin
               state_d = IDLE;
            end
         end
         BUS_D: begin
            if (!(d_req && m_waitrequest)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: connect the owner straight through to the slave and stall
   // everyone else.
   always_comb begin
      owner         = state_q;
      m_address     = '0;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_writedata   = '0;
      m_byteenable  = '0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = '0;
      d_readdata    = '0;
      case (state_q)
         BUS_I: begin
            m_address     = i_address;
            m_read        = i_read;
            m_byteenable  = ALL_LANES;
            i_waitrequest = m_waitrequest;
            i_readdata    = m_readdata;
         end
         BUS_D: begin
            m_address     = d_address;
            // A write takes precedence if the data port asserts both strobes.
            m_read        = d_read & ~d_write;
            m_write       = d_write;
            m_writedata   = d_writedata;
            m_byteenable  = d_byteenable;
            d_waitrequest = m_waitrequest;
            d_readdata    = m_readdata;
         end
         default: begin
            owner = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_avalon_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_avalon_mem_arbiter
// Description : Directed, table-driven bench for avalon_mem_arbiter, with
//               hand-written reset and arbitration-order sequences.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_avalon_mem_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] i_address;
   logic        i_read;
   logic [31:0] i_readdata;
   logic        i_waitrequest;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic [31:0] d_readdata;
   logic        d_waitrequest;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic [31:0] m_readdata;
   logic        m_waitrequest;
   logic [1:0]  owner;

   int n_tests;
   int n_fail;

   avalon_mem_arbiter #(.ADDR_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_address    (i_address),
      .i_read       (i_read),
      .i_readdata   (i_readdata),
      .i_waitrequest(i_waitrequest),
      .d_address    (d_address),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_writedata  (d_writedata),
      .d_byteenable (d_byteenable),
      .d_readdata   (d_readdata),
      .d_waitrequest(d_waitrequest),
      .m_address    (m_address),
      .m_read       (m_read),
      .m_write      (m_write),
      .m_writedata  (m_writedata),
      .m_byteenable (m_byteenable),
      .m_readdata   (m_readdata),
      .m_waitrequest(m_waitrequest),
      .owner        (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [3:0]  dbe;
      logic [31:0] mrd;
      logic        mw;
      logic [1:0]  e_own;
      logic        e_mr;
      logic        e_mwr;
      logic [31:0] e_ma;
      logic [3:0]  e_mbe;
      logic [31:0] e_mwd;
      logic        e_iw;
      logic        e_dw;
      logic [31:0] e_ird;
      logic [31:0] e_drd;
   } vec_t;

   vec_t vt[24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic setv(input int k,
                       input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] dbe,
                       input logic [31:0] mrd, input logic mw,
                       input logic [1:0] e_own, input logic e_mr, input logic e_mwr,
                       input logic [31:0] e_ma, input logic [3:0] e_mbe,
                       input logic [31:0] e_mwd, input logic e_iw, input logic e_dw,
                       input logic [31:0] e_ird, input logic [31:0] e_drd);
      vt[k] = '{ir, ia, dr, dw, da, dwd, dbe, mrd, mw,
                e_own, e_mr, e_mwr, e_ma, e_mbe, e_mwd, e_iw, e_dw, e_ird, e_drd};
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [3:0] dbe, input logic [31:0] mrd, input logic mw);
      i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da;
      d_writedata = dwd; d_byteenable = dbe; m_readdata = mrd; m_waitrequest = mw;
   endtask

   initial begin
      logic [1:0] grants[4];
      logic [1:0] exp_g[4];
      int         ng;
      bit         seen;

      n_tests = 0;
      n_fail  = 0;

      //     ir ia     dr dw da      dwd           dbe    mrd           mw  own   mr mwr ma      mbe    mwd           iw dw ird           drd
      setv(0,  0, 0,     0, 0, 0,      0,            4'h0, 0,            0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      // single instruction read
      setv(1,  1, 32'h4, 0, 0, 0,      0,            4'h0, 32'h24020010, 0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      setv(2,  1, 32'h4, 0, 0, 0,      0,            4'h0, 32'h24020010, 0, 2'b01, 1, 0, 32'h4,  4'hF, 0,            0, 1, 32'h24020010, 0);
      setv(3,  0, 0,     0, 0, 0,      0,            4'h0, 32'h24020010, 0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      // contested: data write wins, instruction follows
      setv(4,  1, 32'h8, 0, 1, 32'h100, 32'hF0,       4'hF, 0,            0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      setv(5,  1, 32'h8, 0, 1, 32'h100, 32'hF0,       4'hF, 0,            0, 2'b10, 0, 1, 32'h100, 4'hF, 32'hF0,      1, 0, 0,            0);
      setv(6,  1, 32'h8, 0, 0, 0,      0,            4'h0, 32'h11112222, 0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      setv(7,  1, 32'h8, 0, 0, 0,      0,            4'h0, 32'h11112222, 0, 2'b01, 1, 0, 32'h8,  4'hF, 0,            0, 1, 32'h11112222, 0);
      setv(8,  0, 0,     0, 0, 0,      0,            4'h0, 0,            0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      // read and write together: the write is forwarded
      setv(9,  0, 0,     1, 1, 32'h200, 32'hAABBCCDD, 4'h3, 32'h55,       0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      setv(10, 0, 0,     1, 1, 32'h200, 32'hAABBCCDD, 4'h3, 32'h55,       0, 2'b10, 0, 1, 32'h200, 4'h3, 32'hAABBCCDD, 1, 0, 0,            32'h55);
      setv(11, 0, 0,     0, 0, 0,      0,            4'h0, 0,            0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      // data read stalled for 3 cycles while instruction waits
      setv(12, 0, 0,     1, 0, 32'h300, 0,            4'hF, 0,            1, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      setv(13, 1, 32'hC, 1, 0, 32'h300, 0,            4'hF, 32'hDEAD0000, 1, 2'b10, 1, 0, 32'h300, 4'hF, 0,            1, 1, 0,            32'hDEAD0000);
      setv(14, 1, 32'hC, 1, 0, 32'h300, 0,            4'hF, 32'hDEAD0000, 1, 2'b10, 1, 0, 32'h300, 4'hF, 0,            1, 1, 0,            32'hDEAD0000);
      setv(15, 1, 32'hC, 1, 0, 32'h300, 0,            4'hF, 32'hDEAD0000, 1, 2'b10, 1, 0, 32'h300, 4'hF, 0,            1, 1, 0,            32'hDEAD0000);
      setv(16, 1, 32'hC, 1, 0, 32'h300, 0,            4'hF, 32'h12345678, 0, 2'b10, 1, 0, 32'h300, 4'hF, 0,            1, 0, 0,            32'h12345678);
      setv(17, 1, 32'hC, 0, 0, 0,      0,            4'h0, 32'h12345678, 0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      setv(18, 1, 32'hC, 0, 0, 0,      0,            4'h0, 32'h0BADF00D, 0, 2'b01, 1, 0, 32'hC,  4'hF, 0,            0, 1, 32'h0BADF00D, 0);
      setv(19, 0, 0,     0, 0, 0,      0,            4'h0, 0,            0, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      // owner withdraws during a stall: the transfer is aborted
      setv(20, 1, 32'h10, 0, 0, 0,     0,            4'h0, 0,            1, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);
      setv(21, 1, 32'h10, 0, 0, 0,     0,            4'h0, 32'h77,       1, 2'b01, 1, 0, 32'h10, 4'hF, 0,            1, 1, 32'h77,       0);
      setv(22, 0, 32'h10, 0, 0, 0,     0,            4'h0, 32'h77,       1, 2'b01, 0, 0, 32'h10, 4'hF, 0,            1, 1, 32'h77,       0);
      setv(23, 0, 0,     0, 0, 0,      0,            4'h0, 0,            1, 2'b00, 0, 0, 0,      4'h0, 0,            1, 1, 0,            0);

      // Reset state, with both ports requesting.
      reset = 1'b1;
      drive(1, 32'h4, 1, 0, 32'h8, 0, 4'hF, 32'hFFFFFFFF, 0);
      #2;
      check("rst owner", {30'd0, owner}, 32'd0);
      check("rst m_read", {31'd0, m_read}, 32'd0);
      check("rst m_write", {31'd0, m_write}, 32'd0);
      check("rst i_wait", {31'd0, i_waitrequest}, 32'd1);
      check("rst d_wait", {31'd0, d_waitrequest}, 32'd1);
      check("rst i_rdata", i_readdata, 32'd0);
      check("rst d_rdata", d_readdata, 32'd0);
      drive(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Table vectors: apply at the falling edge, compare before the next rise.
      for (int i = 0; i < 24; i++) begin
         drive(vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dwd,
               vt[i].dbe, vt[i].mrd, vt[i].mw);
         #1;
         check($sformatf("v%0d owner", i), {30'd0, owner}, {30'd0, vt[i].e_own});
         check($sformatf("v%0d m_read", i), {31'd0, m_read}, {31'd0, vt[i].e_mr});
         check($sformatf("v%0d m_write", i), {31'd0, m_write}, {31'd0, vt[i].e_mwr});
         check($sformatf("v%0d m_address", i), m_address, vt[i].e_ma);
         check($sformatf("v%0d m_byteenable", i), {28'd0, m_byteenable}, {28'd0, vt[i].e_mbe});
         check($sformatf("v%0d m_writedata", i), m_writedata, vt[i].e_mwd);
         check($sformatf("v%0d i_wait", i), {31'd0, i_waitrequest}, {31'd0, vt[i].e_iw});
         check($sformatf("v%0d d_wait", i), {31'd0, d_waitrequest}, {31'd0, vt[i].e_dw});
         check($sformatf("v%0d i_rdata", i), i_readdata, vt[i].e_ird);
         check($sformatf("v%0d d_rdata", i), d_readdata, vt[i].e_drd);
         @(negedge clk);
      end

      // Reset pulsed during an instruction grant aborts it at once.
      drive(1, 32'h40, 0, 0, 0, 0, 4'h0, 32'h99, 1);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         #1;
         if (owner == 2'b01) seen = 1'b1;
      end
      check("rst-mid grant seen", {31'd0, seen}, 32'd1);
      reset = 1'b1;
      #1;
      check("rst-mid owner", {30'd0, owner}, 32'd0);
      check("rst-mid m_read", {31'd0, m_read}, 32'd0);
      check("rst-mid i_wait", {31'd0, i_waitrequest}, 32'd1);
      check("rst-mid i_rdata", i_readdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst-rel regrant owner", {30'd0, owner}, 32'd1);
      check("rst-rel m_address", m_address, 32'h40);

      // Continuous contention after reset: the order depends on the build.
      @(negedge clk);
      reset = 1'b1;
      drive(1, 32'h50, 1, 0, 32'h60, 0, 4'hF, 32'h1, 0);
      @(negedge clk);
      reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
      exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
      ng = 0;
      for (int c = 0; c < 20 && ng < 4; c++) begin
         @(posedge clk);
         #1;
         if (owner != 2'b00) begin
            grants[ng] = owner;
            ng++;
         end
      end
      check("contend grant count", ng, 32'd4);
      for (int g = 0; g < ng; g++) begin
         check($sformatf("contend grant %0d", g), {30'd0, grants[g]}, {30'd0, exp_g[g]});
      end
      drive(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
